// File: rtl/softmax_argmax_sequencer.sv
// Sequential argmax over NUM_CLASSES softmax scores read one per cycle from a score buffer.
// Optional runner-up tracking is enabled by defining SOFTMAX_ARGMAX_TOP2_EN.
module softmax_argmax_sequencer #(
  parameter int datawidth   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDXW        = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 rd_en,
  output logic [IDXW-1:0]      rd_addr,
  input  logic [datawidth-1:0] rd_data,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [datawidth-1:0] max_out,
  output logic [IDXW-1:0]      max_index,
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  output logic [datawidth-1:0] second_out,
  output logic [IDXW-1:0]      second_index,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_CLASSES - 1);

  // Handshake: result_valid rises in DONE and stays high, with max_out/max_index
  // frozen, until an edge where result_valid & result_ready are both high.

  state_t                r_state, w_state_n;
  logic [IDXW-1:0]       r_addr;
  logic                  r_dv;
  logic [IDXW-1:0]       r_didx;
  logic [datawidth-1:0]  r_run_max, w_run_max_n;
  logic [IDXW-1:0]       r_run_idx, w_run_idx_n;
  logic [datawidth-1:0]  r_max_out;
  logic [IDXW-1:0]       r_max_index;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  logic [datawidth-1:0]  r_run_sec, w_run_sec_n;
  logic [IDXW-1:0]       r_run_sidx, w_run_sidx_n;
  logic [datawidth-1:0]  r_sec_out;
  logic [IDXW-1:0]       r_sec_index;
`endif

  // Maps an IEEE-754 bit pattern to an unsigned key with the same ordering.
  function automatic logic [datawidth-1:0] f_key(input logic [datawidth-1:0] x);
    f_key = x[datawidth-1] ? ~x : (x | {1'b1, {(datawidth-1){1'b0}}});
  endfunction

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n    = r_state;
    busy         = (r_state != S_IDLE);
    rd_en        = (r_state == S_READ);
    result_valid = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (start) w_state_n = S_READ;
      S_READ:  if (r_addr == LAST) w_state_n = S_DRAIN;
      S_DRAIN: w_state_n = S_DONE;
      S_DONE:  if (result_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr <= '0;
      r_dv   <= 1'b0;
      r_didx <= '0;
    end else begin
      if (r_state == S_READ) r_addr <= (r_addr == LAST) ? '0 : r_addr + 1'b1;
      r_dv   <= rd_en;
      r_didx <= r_addr;
    end
  end

  // Compare stage: rd_data belongs to r_didx whenever r_dv is high.
  always_comb begin
    w_run_max_n  = r_run_max;
    w_run_idx_n  = r_run_idx;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    w_run_sec_n  = r_run_sec;
    w_run_sidx_n = r_run_sidx;
`endif
    if (r_dv) begin
      if (r_didx == '0) begin
        w_run_max_n = rd_data;
        w_run_idx_n = '0;
      end else if (f_key(rd_data) > f_key(r_run_max)) begin
        w_run_max_n  = rd_data;
        w_run_idx_n  = r_didx;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
        w_run_sec_n  = r_run_max;
        w_run_sidx_n = r_run_idx;
      end else if ((r_didx == IDXW'(1)) || (f_key(rd_data) > f_key(r_run_sec))) begin
        w_run_sec_n  = rd_data;
        w_run_sidx_n = r_didx;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_run_max   <= '0;
      r_run_idx   <= '0;
      r_max_out   <= '0;
      r_max_index <= '0;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      r_run_sec   <= '0;
      r_run_sidx  <= '0;
      r_sec_out   <= '0;
      r_sec_index <= '0;
`endif
    end else begin
      r_run_max <= w_run_max_n;
      r_run_idx <= w_run_idx_n;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      r_run_sec  <= w_run_sec_n;
      r_run_sidx <= w_run_sidx_n;
`endif
      // The final sample is folded in during DRAIN, so publish the post-update value.
      if (r_state == S_DRAIN) begin
        r_max_out   <= w_run_max_n;
        r_max_index <= w_run_idx_n;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
        r_sec_out   <= w_run_sec_n;
        r_sec_index <= w_run_sidx_n;
`endif
      end
    end
  end

  assign rd_addr   = r_addr;
  assign max_out   = r_max_out;
  assign max_index = r_max_index;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  assign second_out   = r_sec_out;
  assign second_index = r_sec_index;
`endif
  assign dbg_state = r_state;

endmodule

// File: tb/tb_softmax_argmax_sequencer.sv
// Self-checking bench for softmax_argmax_sequencer: score buffer responder, rank-based
// argmax reference model, and scenario tasks for timing, ordering, backpressure and reset.
module tb_softmax_argmax_sequencer;
  localparam int W = 32;
  localparam int N = 10;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, rd_en, result_valid;
  logic          result_ready = 1'b0;
  logic [IW-1:0] rd_addr, max_index;
  logic [W-1:0]  rd_data = '0;
  logic [W-1:0]  max_out;
  logic [1:0]    dbg_state;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  logic [W-1:0]  second_out;
  logic [IW-1:0] second_index;
  logic [IW-1:0] exp_sq[$];
`endif

  int total = 0;
  int bad = 0;
  int tb_cyc = 0;

  logic [W-1:0]  mem [16];
  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] exp_iq[$];
  int            log_addr[$];
  int            log_cyc[$];
  int            run_base;

  softmax_argmax_sequencer #(.datawidth(W), .NUM_CLASSES(N), .IDXW(IW)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .max_out(max_out), .max_index(max_index),
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    .second_out(second_out), .second_index(second_index),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) tb_cyc++;

  // Score buffer: one-cycle read latency; garbage on cycles not following a read.
  always begin : responder
    logic         s_en;
    logic [IW-1:0] s_addr;
    @(negedge clock);
    s_en   = rd_en;
    s_addr = rd_addr;
    if (s_en === 1'b1) begin
      log_addr.push_back(int'(s_addr));
      log_cyc.push_back(tb_cyc);
    end
    @(posedge clock);
    #1;
    rd_data = (s_en === 1'b1) ? mem[s_addr] : $urandom;
  end

  // Signed rank: +m ranks as m, -m ranks as -m-1 (so -0 sits just below +0).
  function automatic longint rank(input logic [W-1:0] x);
    longint m;
    m = longint'(x[W-2:0]);
    return x[W-1] ? (-m - 1) : m;
  endfunction

  task automatic model_expect();
    int best;
    best = 0;
    for (int i = 1; i < N; i++)
      if (rank(mem[i]) > rank(mem[best])) best = i;
    exp_q.push_back(mem[best]);
    exp_iq.push_back(IW'(best));
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    begin
      int sec;
      sec = -1;
      for (int i = 0; i < N; i++)
        if (i != best && (sec < 0 || rank(mem[i]) > rank(mem[sec]))) sec = i;
      exp_sq.push_back(IW'(sec));
    end
`endif
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Driver: runs one classification; start is held in cycle 0 (accepted at edge E0).
  task automatic run_class(input int ready_delay, input bit poke,
                           output int o_cyc, output logic [W-1:0] o_max,
                           output logic [IW-1:0] o_idx, output bit o_stable,
                           output int o_nreads, output bit o_seq_ok,
                           output logic o_busy_after, output logic o_valid_after,
                           output logic o_idle_again);
    int cyc;
    model_expect();
    result_ready = 1'b0;
    log_addr.delete();
    log_cyc.delete();
    run_base = tb_cyc;
    start = 1'b1;
    step();
    cyc = 1;
    start = 1'b0;
    while (result_valid !== 1'b1 && cyc < 40) begin
      start = poke && (cyc == 4 || cyc == 11);
      step();
      cyc++;
    end
    start = 1'b0;
    o_cyc = (result_valid === 1'b1) ? cyc : -1;
    o_max = max_out;
    o_idx = max_index;
    o_stable = 1'b1;
    for (int k = 0; k < ready_delay; k++) begin
      start = poke && (k == 1);
      step();
      if (result_valid !== 1'b1 || rd_en !== 1'b0 || max_out !== o_max || max_index !== o_idx)
        o_stable = 1'b0;
    end
    result_ready = 1'b1;
    start = poke;
    step();
    start = 1'b0;
    result_ready = 1'b0;
    o_busy_after = busy;
    o_valid_after = result_valid;
    step();
    o_idle_again = ~busy;
    o_nreads = log_addr.size();
    o_seq_ok = (log_addr.size() == N);
    for (int i = 0; i < log_addr.size() && i < N; i++)
      if (log_addr[i] != i || log_cyc[i] != run_base + 1 + i) o_seq_ok = 1'b0;
  endtask

  // Shared post-run checks are written out per scenario; this holds the run results.
  int            r_cyc, r_nreads;
  logic [W-1:0]  r_max, e_max;
  logic [IW-1:0] r_idx, e_idx;
  bit            r_stable, r_seq;
  logic          r_busy_a, r_valid_a, r_idle2;

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    total++; if (rd_addr !== 4'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
    total++; if (max_out !== 32'd0) begin bad++; $display("FAIL reset_max_out got=%h want=0", max_out); end
    total++; if (max_index !== 4'd0) begin bad++; $display("FAIL reset_max_index got=%0d want=0", max_index); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_distinct_max();
    logic [W-1:0] vals[N];
    vals = '{32'h3C23D70A, 32'h3CA3D70A, 32'h3CF5C28F, 32'h3D23D70A, 32'h3D4CCCCD,
             32'h3D75C28F, 32'h3D8F5C29, 32'h3F1EB852, 32'h3DA3D70A, 32'h3DB851EC};
    for (int i = 0; i < N; i++) mem[i] = vals[i];
    run_class(0, 1'b0, r_cyc, r_max, r_idx, r_stable, r_nreads, r_seq, r_busy_a, r_valid_a, r_idle2);
    e_max = exp_q.pop_front();
    e_idx = exp_iq.pop_front();
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    void'(exp_sq.pop_front());
`endif
    total++; if (r_cyc != N + 2) begin bad++; $display("FAIL distinct_latency got=%0d want=%0d", r_cyc, N + 2); end
    total++; if (r_seq !== 1'b1) begin bad++; $display("FAIL distinct_read_seq got=%0d reads want=%0d in cycles 1..%0d", r_nreads, N, N); end
    total++; if (r_max !== e_max) begin bad++; $display("FAIL distinct_max_out got=%h want=%h", r_max, e_max); end
    total++; if (r_idx !== 4'd7) begin bad++; $display("FAIL distinct_max_index got=%0d want=7", r_idx); end
    total++; if (r_busy_a !== 1'b0) begin bad++; $display("FAIL distinct_busy_after got=%b want=0", r_busy_a); end
    total++; if (r_valid_a !== 1'b0) begin bad++; $display("FAIL distinct_valid_after got=%b want=0", r_valid_a); end
    total++; if (max_out !== e_max) begin bad++; $display("FAIL distinct_hold_after got=%h want=%h", max_out, e_max); end
  endtask

  task automatic test_tie();
    for (int i = 0; i < N; i++) mem[i] = 32'h3D000000;
    mem[3] = 32'h3F000000;
    mem[8] = 32'h3F000000;
    run_class(0, 1'b0, r_cyc, r_max, r_idx, r_stable, r_nreads, r_seq, r_busy_a, r_valid_a, r_idle2);
    e_max = exp_q.pop_front();
    e_idx = exp_iq.pop_front();
    total++; if (r_idx !== e_idx) begin bad++; $display("FAIL tie_max_index got=%0d want=%0d", r_idx, e_idx); end
    total++; if (r_max !== e_max) begin bad++; $display("FAIL tie_max_out got=%h want=%h", r_max, e_max); end
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    begin
      logic [IW-1:0] e_s;
      e_s = exp_sq.pop_front();
      total++; if (second_index !== e_s) begin bad++; $display("FAIL tie_second_index got=%0d want=%0d", second_index, e_s); end
      total++; if (second_out !== 32'h3F000000) begin bad++; $display("FAIL tie_second_out got=%h want=3f000000", second_out); end
    end
`endif
  endtask

  task automatic test_all_equal_and_negative();
    for (int i = 0; i < N; i++) mem[i] = 32'h3DCCCCCD;
    run_class(0, 1'b0, r_cyc, r_max, r_idx, r_stable, r_nreads, r_seq, r_busy_a, r_valid_a, r_idle2);
    e_max = exp_q.pop_front();
    e_idx = exp_iq.pop_front();
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    void'(exp_sq.pop_front());
`endif
    total++; if (r_idx !== e_idx) begin bad++; $display("FAIL equal_max_index got=%0d want=%0d", r_idx, e_idx); end
    for (int i = 0; i < N; i++) mem[i] = 32'h80000000;
    mem[2] = 32'hBF800000;
    mem[5] = 32'h00000000;
    run_class(0, 1'b0, r_cyc, r_max, r_idx, r_stable, r_nreads, r_seq, r_busy_a, r_valid_a, r_idle2);
    e_max = exp_q.pop_front();
    e_idx = exp_iq.pop_front();
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    void'(exp_sq.pop_front());
`endif
    total++; if (r_idx !== e_idx) begin bad++; $display("FAIL negative_max_index got=%0d want=%0d", r_idx, e_idx); end
    total++; if (r_max !== e_max) begin bad++; $display("FAIL negative_max_out got=%h want=%h", r_max, e_max); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    run_class(5, 1'b1, r_cyc, r_max, r_idx, r_stable, r_nreads, r_seq, r_busy_a, r_valid_a, r_idle2);
    e_max = exp_q.pop_front();
    e_idx = exp_iq.pop_front();
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    void'(exp_sq.pop_front());
`endif
    total++; if (r_stable !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b want=1", r_stable); end
    total++; if (r_nreads != N) begin bad++; $display("FAIL bp_read_count got=%0d want=%0d", r_nreads, N); end
    total++; if (r_cyc != N + 2) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", r_cyc, N + 2); end
    total++; if (r_max !== e_max || r_idx !== e_idx) begin bad++; $display("FAIL bp_result got=%h/%0d want=%h/%0d", r_max, r_idx, e_max, e_idx); end
    total++; if (r_idle2 !== 1'b1) begin bad++; $display("FAIL bp_start_at_handshake busy_two_cycles_later got=%b want=0", ~r_idle2); end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 4; c++) step();
    total++; if (rd_addr !== 4'd3 || rd_en !== 1'b1) begin bad++; $display("FAIL midrst_in_read got=%b/%0d want=1/3", rd_en, rd_addr); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (busy !== 1'b0 || rd_en !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got busy=%b rd_en=%b valid=%b want 0/0/0", busy, rd_en, result_valid);
    end
    total++; if (max_out !== 32'd0) begin bad++; $display("FAIL midrst_max_out got=%h want=0", max_out); end
    step();
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    run_class(0, 1'b0, r_cyc, r_max, r_idx, r_stable, r_nreads, r_seq, r_busy_a, r_valid_a, r_idle2);
    e_max = exp_q.pop_front();
    e_idx = exp_iq.pop_front();
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    void'(exp_sq.pop_front());
`endif
    total++; if (r_cyc != N + 2) begin bad++; $display("FAIL midrst_fresh_latency got=%0d want=%0d", r_cyc, N + 2); end
    total++; if (r_max !== e_max || r_idx !== e_idx) begin bad++; $display("FAIL midrst_fresh_result got=%h/%0d want=%h/%0d", r_max, r_idx, e_max, e_idx); end
  endtask

  task automatic test_random();
    logic [W-1:0] pool[4];
    pool = '{32'h3F000000, 32'h80000000, 32'h00000000, 32'hBF800000};
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        mem[i] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      run_class($urandom_range(0, 3), 1'($urandom_range(0, 1)), r_cyc, r_max, r_idx, r_stable,
                r_nreads, r_seq, r_busy_a, r_valid_a, r_idle2);
      e_max = exp_q.pop_front();
      e_idx = exp_iq.pop_front();
      total++; if (r_max !== e_max || r_idx !== e_idx) begin
        bad++; $display("FAIL random_%0d_result got=%h/%0d want=%h/%0d", t, r_max, r_idx, e_max, e_idx);
      end
`ifdef SOFTMAX_ARGMAX_TOP2_EN
      begin
        logic [IW-1:0] e_s;
        e_s = exp_sq.pop_front();
        total++; if (second_index !== e_s) begin bad++; $display("FAIL random_%0d_second got=%0d want=%0d", t, second_index, e_s); end
      end
`endif
      total++; if (r_seq !== 1'b1 || r_stable !== 1'b1) begin
        bad++; $display("FAIL random_%0d_protocol got seq=%b stable=%b want 1/1", t, r_seq, r_stable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_distinct_max();
    test_tie();
    test_all_equal_and_negative();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
